// File: rtl/pow3_stream_checker_if.sv
// Valid/ready stream bundle feeding the power-of-3 checker.
// The master drives beats and the slave (the checker) returns ready.
interface pow3_stream_checker_if #(
  parameter int DATA_SIZE = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/pow3_stream_checker.sv
// Consumer-side checker: each accepted beat must be three times the previous one.
// Optional macro POW3_CHECK_WRAP_EN lets the expected value wrap modulo 2^DATA_SIZE.
module pow3_stream_checker #(
  parameter int DATA_SIZE = 32,
  parameter int ERR_HOLD  = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pow3_stream_checker_if.slave s_in,
  output logic                 locked,
  output logic [7:0]           exponent,
  output logic [CNT_W-1:0]     match_count,
  output logic [CNT_W-1:0]     error_count,
  output logic                 error_flag
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ERR    = 2'd2,
    ST_RESYNC = 2'd3
  } state_t;

  state_t                r_state;
  logic [DATA_SIZE-1:0]  r_expected;
  logic [7:0]            r_exponent;
  logic [CNT_W-1:0]      r_match;
  logic [CNT_W-1:0]      r_err;
  logic                  r_flag;
  logic                  r_ready;
  logic                  r_locked;
  logic [7:0]            r_hold;

  state_t                w_state_nx;
  logic [DATA_SIZE-1:0]  w_expected_nx;
  logic [7:0]            w_exponent_nx;
  logic [CNT_W-1:0]      w_match_nx;
  logic [CNT_W-1:0]      w_err_nx;
  logic                  w_flag_nx;
  logic [7:0]            w_hold_nx;

  logic                  w_accept;
  logic [DATA_SIZE+1:0]  w_prod;
  logic                  w_ovf;
  logic [CNT_W-1:0]      w_match_inc;
  logic [CNT_W-1:0]      w_err_inc;
  logic                  w_is_one;
  logic                  w_is_exp;

  assign w_accept    = s_in.in_valid & r_ready;
  // 3x computed as x + 2x; the top two bits flag overflow past DATA_SIZE.
  assign w_prod      = {2'b00, r_expected} + {1'b0, r_expected, 1'b0};
  assign w_ovf       = |w_prod[DATA_SIZE+1:DATA_SIZE];
  assign w_match_inc = (r_match == {CNT_W{1'b1}}) ? r_match : r_match + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_err_inc   = (r_err   == {CNT_W{1'b1}}) ? r_err   : r_err   + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_is_one    = (s_in.in_data == {{(DATA_SIZE-1){1'b0}}, 1'b1});
  assign w_is_exp    = (s_in.in_data == r_expected);

  // Next-state and next-value logic for the tracking FSM.
  always_comb begin
    w_state_nx    = r_state;
    w_expected_nx = r_expected;
    w_exponent_nx = r_exponent;
    w_match_nx    = r_match;
    w_err_nx      = r_err;
    w_flag_nx     = 1'b0;
    w_hold_nx     = r_hold;
    case (r_state)
      ST_IDLE, ST_RESYNC: begin
        if (w_accept) begin
          if (w_is_one) begin
            w_state_nx    = ST_LOCKED;
            w_exponent_nx = 8'd0;
            w_match_nx    = w_match_inc;
            w_expected_nx = {{(DATA_SIZE-2){1'b0}}, 2'b11};
          end else if (r_state == ST_IDLE) begin
            w_state_nx = ST_ERR;
            w_err_nx   = w_err_inc;
            w_flag_nx  = 1'b1;
            w_hold_nx  = 8'(ERR_HOLD - 1);
          end else begin
            w_state_nx = r_state;
          end
        end else begin
          w_state_nx = r_state;
        end
      end
      ST_LOCKED: begin
        if (w_accept) begin
          if (w_is_exp) begin
            w_match_nx    = w_match_inc;
            w_exponent_nx = r_exponent + 8'd1;
`ifdef POW3_CHECK_WRAP_EN
            w_expected_nx = w_prod[DATA_SIZE-1:0];
`else
            // Past the last representable power the stream must restart from 1.
            if (w_ovf) begin
              w_state_nx    = ST_IDLE;
              w_expected_nx = {{(DATA_SIZE-1){1'b0}}, 1'b1};
            end else begin
              w_expected_nx = w_prod[DATA_SIZE-1:0];
            end
`endif
          end else begin
            w_state_nx = ST_ERR;
            w_err_nx   = w_err_inc;
            w_flag_nx  = 1'b1;
            w_hold_nx  = 8'(ERR_HOLD - 1);
          end
        end else begin
          w_state_nx = r_state;
        end
      end
      ST_ERR: begin
        if (r_hold == 8'd0) begin
          w_state_nx = ST_RESYNC;
        end else begin
          w_hold_nx = r_hold - 8'd1;
        end
      end
      default: begin
        w_state_nx    = ST_IDLE;
        w_expected_nx = {{(DATA_SIZE-1){1'b0}}, 1'b1};
      end
    endcase
  end

  // State and registered outputs; ready/locked are derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_expected <= {{(DATA_SIZE-1){1'b0}}, 1'b1};
      r_exponent <= 8'd0;
      r_match    <= {CNT_W{1'b0}};
      r_err      <= {CNT_W{1'b0}};
      r_flag     <= 1'b0;
      r_ready    <= 1'b0;
      r_locked   <= 1'b0;
      r_hold     <= 8'd0;
    end else begin
      r_state    <= w_state_nx;
      r_expected <= w_expected_nx;
      r_exponent <= w_exponent_nx;
      r_match    <= w_match_nx;
      r_err      <= w_err_nx;
      r_flag     <= w_flag_nx;
      r_ready    <= (w_state_nx != ST_ERR);
      r_locked   <= (w_state_nx == ST_LOCKED);
      r_hold     <= w_hold_nx;
    end
  end

  assign s_in.in_ready = r_ready;
  assign locked        = r_locked;
  assign exponent      = r_exponent;
  assign match_count   = r_match;
  assign error_count   = r_err;
  assign error_flag    = r_flag;

endmodule

// File: tb/tb_pow3_stream_checker.sv
// Self-checking bench: directed vector table, overflow/reset sequences,
// and randomized beats compared against a behavioural model of the checker.
module tb_pow3_stream_checker;
  localparam int DW   = 32;
  localparam int HOLD = 4;
  localparam int CW   = 16;

  localparam int M_IDLE   = 0;
  localparam int M_LOCKED = 1;
  localparam int M_ERR    = 2;
  localparam int M_RESYNC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          locked;
  logic [7:0]    exponent;
  logic [CW-1:0] match_count;
  logic [CW-1:0] error_count;
  logic          error_flag;

  int checks = 0;
  int errors = 0;

  pow3_stream_checker_if #(.DATA_SIZE(DW)) bus ();

  pow3_stream_checker #(.DATA_SIZE(DW), .ERR_HOLD(HOLD), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_in        (bus.slave),
    .locked      (locked),
    .exponent    (exponent),
    .match_count (match_count),
    .error_count (error_count),
    .error_flag  (error_flag)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int     m_mode;
  longint m_next;
  int     m_exp, m_match, m_err, m_hold;
  bit     m_flag, m_ready;

  task automatic model_reset();
    m_mode = M_IDLE; m_next = 1; m_exp = 0; m_match = 0; m_err = 0;
    m_hold = 0; m_flag = 0; m_ready = 0;
  endtask

  task automatic model_mismatch();
    if (m_err < 65535) m_err++;
    m_flag = 1; m_mode = M_ERR; m_hold = HOLD;
  endtask

  task automatic model_relock();
    m_mode = M_LOCKED; m_exp = 0; m_next = 3;
    if (m_match < 65535) m_match++;
  endtask

  task automatic model_edge(input bit v, input longint d);
    bit acc;
    acc = v && m_ready;
    m_flag = 0;
    case (m_mode)
      M_IDLE, M_RESYNC: begin
        if (acc && d == 1) model_relock();
        else if (acc && m_mode == M_IDLE) model_mismatch();
      end
      M_LOCKED: begin
        if (acc && d == m_next) begin
          if (m_match < 65535) m_match++;
          m_exp = (m_exp + 1) % 256;
`ifdef POW3_CHECK_WRAP_EN
          m_next = (m_next * 3) % (64'd1 << 32);
`else
          if (m_next * 3 >= (64'd1 << 32)) begin
            m_mode = M_IDLE; m_next = 1;
          end else begin
            m_next = m_next * 3;
          end
`endif
        end else if (acc) begin
          model_mismatch();
        end
      end
      M_ERR: begin
        m_hold--;
        if (m_hold == 0) m_mode = M_RESYNC;
      end
      default: m_mode = M_IDLE;
    endcase
    m_ready = (m_mode != M_ERR);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".locked"},   locked,        m_mode == M_LOCKED);
    chk({tag, ".exponent"}, exponent,      m_exp);
    chk({tag, ".match"},    match_count,   m_match);
    chk({tag, ".errcnt"},   error_count,   m_err);
    chk({tag, ".flag"},     error_flag,    m_flag);
    chk({tag, ".ready"},    bus.in_ready,  m_ready);
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input string tag);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    model_edge(v, longint'(d));
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 64'd0);
    #1;
    check_model("release");
  endtask

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          lk;
    int          ex;
    int          mc;
    int          ec;
    bit          fl;
    bit          rd;
  } vec_t;

  vec_t tbl[16];

  initial begin
    longint p;
    int     r;
    logic [31:0] rd;

    tbl[0]  = '{1'b1, 32'd1,  1'b1, 0, 1, 0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 32'd3,  1'b1, 1, 2, 0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 32'd9,  1'b1, 2, 3, 0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 32'd27, 1'b1, 3, 4, 0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 32'd5,  1'b1, 3, 4, 0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 32'd10, 1'b0, 3, 4, 1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 32'd1,  1'b0, 3, 4, 1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 32'd1,  1'b0, 3, 4, 1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 32'd1,  1'b0, 3, 4, 1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 32'd5,  1'b0, 3, 4, 1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 32'd5,  1'b0, 3, 4, 1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 32'd7,  1'b0, 3, 4, 1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 32'd1,  1'b1, 0, 5, 1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 32'd3,  1'b1, 1, 6, 1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 32'd10, 1'b0, 1, 6, 2, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 32'd0,  1'b0, 1, 6, 2, 1'b0, 1'b0};

    // Reset values are fixed by the block's contract, independent of the model.
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.locked", locked, 0);
    chk("rst.ready",  bus.in_ready, 0);
    chk("rst.match",  match_count, 0);
    chk("rst.errcnt", error_count, 0);
    chk("rst.flag",   error_flag, 0);
    chk("rst.exp",    exponent, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 64'd0);
    #1;
    chk("rel.ready",  bus.in_ready, 1);
    chk("rel.locked", locked, 0);

    // Directed table: clean stream, mismatch, error hold, resync.
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = tbl[i].v;
      bus.in_data  = tbl[i].d;
      @(posedge clk);
      model_edge(tbl[i].v, longint'(tbl[i].d));
      #1;
      chk($sformatf("tbl%0d.locked", i), locked,       tbl[i].lk);
      chk($sformatf("tbl%0d.exp", i),    exponent,     tbl[i].ex);
      chk($sformatf("tbl%0d.match", i),  match_count,  tbl[i].mc);
      chk($sformatf("tbl%0d.err", i),    error_count,  tbl[i].ec);
      chk($sformatf("tbl%0d.flag", i),   error_flag,   tbl[i].fl);
      chk($sformatf("tbl%0d.ready", i),  bus.in_ready, tbl[i].rd);
    end

    // Overflow: 3^0..3^20 then the wrapped value of 3^21.
    do_reset();
    p = 1;
    for (int i = 0; i <= 20; i++) begin
      drive(1'b1, p[31:0], "ovf");
      p = p * 3;
    end
    chk("ovf.exp20", exponent, 20);
    drive(1'b1, 32'd1870418611, "ovf_next");
`ifdef POW3_CHECK_WRAP_EN
    chk("ovf.wrap_exp", exponent, 21);
    chk("ovf.wrap_match", match_count, 22);
`else
    chk("ovf.nowrap_err", error_count, 1);
`endif

    // Overflow: restart with 1 after 3^20.
    do_reset();
    p = 1;
    for (int i = 0; i <= 20; i++) begin
      drive(1'b1, p[31:0], "ovf2");
      p = p * 3;
    end
    drive(1'b1, 32'd1, "ovf2_one");
`ifndef POW3_CHECK_WRAP_EN
    chk("ovf2.exp0", exponent, 0);
    chk("ovf2.locked", locked, 1);
`endif

    // Asynchronous reset between edges after three matches.
    do_reset();
    drive(1'b1, 32'd1, "ar");
    drive(1'b1, 32'd3, "ar");
    drive(1'b1, 32'd9, "ar");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("ar.match",  match_count, 0);
    chk("ar.locked", locked, 0);
    chk("ar.ready",  bus.in_ready, 0);
    chk("ar.exp",    exponent, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 64'd0);
    #1;
    check_model("ar_rel");
    drive(1'b1, 32'd1, "ar_relock");
    chk("ar.match1", match_count, 1);

    // Randomized beats against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      rd = 32'd1;
      else if (r < 7) rd = m_next[31:0];
      else if (r < 8) rd = m_next[31:0] + 32'd1;
      else            rd = $urandom;
      drive($urandom_range(0, 3) != 0, rd, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pow3_stream_checker.md
Name: pow3_stream_checker

Overview:
- Consumer end of the power-of-3 stream produced by the existing generator block.
- Accepts 32-bit beats over a valid/ready handshake and checks that each beat equals three times the previous beat.
- Tracks the current exponent, counts matches and errors, and stalls briefly and then resynchronises on a mismatch.
- Sits downstream of the generator in the lab top level and as a self-checking monitor in benches.

Parameters:
- DATA_SIZE, 32, width of in_data and of the internal expected-value register.
- ERR_HOLD, 4, number of cycles in_ready is held low after a mismatch (range 1 to 255).
- CNT_W, 16, width of match_count and error_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a beat.
- in_ready  output  1  block can accept a beat; a beat transfers when in_valid and in_ready are both high at a rising edge.
- in_data  input  DATA_SIZE  stream value.
- locked  output  1  block is tracking a valid sequence.
- exponent  output  8  exponent of the last matched beat.
- match_count  output  CNT_W  number of beats that matched.
- error_count  output  CNT_W  number of beats that mismatched.
- error_flag  output  1  one-cycle pulse on a mismatch.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; expected is set to 1.
  - locked=0, exponent=0, match_count=0, error_count=0, error_flag=0, in_ready=0.
  - in_ready goes to 1 on the first rising edge after rst is released.
  - A reset asserted mid-stream discards state immediately; the beat in flight is not counted.
- All outputs are registered. Effects of an accepted beat are visible in the cycle after the accepting edge (latency 1).
- States: IDLE, LOCKED, ERR, RESYNC. in_ready is 1 in IDLE, LOCKED and RESYNC, and 0 in ERR.
- IDLE:
  - Accepted beat equal to 1: go to LOCKED, exponent=0, match_count+1, expected=3.
  - Accepted beat not equal to 1: error_count+1, error_flag pulse, go to ERR.
- LOCKED:
  - Accepted beat equal to expected: match_count+1, exponent+1, expected=expected*3, truncated to DATA_SIZE bits.
  - Accepted beat not equal to expected: error_count+1, error_flag pulse, locked=0, go to ERR.
- ERR: hold in_ready=0 for exactly ERR_HOLD cycles (internal down-counter), then go to RESYNC.
- RESYNC:
  - Accepted beat equal to 1: go to LOCKED, exponent=0, match_count+1, expected=3.
  - Any other accepted beat is dropped silently and not counted.
- locked=1 only while in LOCKED.
- match_count and error_count saturate at all-ones and never wrap.
- exponent is an 8-bit register and wraps 255 to 0.
- in_valid low means no state change. in_data is ignored when no beat transfers.
- error_flag is high for exactly one cycle per mismatch and is never high in two consecutive cycles.

Optional Feature:
- Macro: POW3_CHECK_WRAP_EN.
- Defined: the product wraps modulo 2^DATA_SIZE and checking continues past overflow. With DATA_SIZE=32, the beat after 3^20 (3486784401) must be 1870418611 to match, and exponent becomes 21.
- Not defined: the last legal exponent is the largest e with 3^e < 2^DATA_SIZE (20 for 32 bits). After that beat is matched, the block behaves as if it were in IDLE:
  - A next beat of 1 relocks with exponent=0 and counts as a match.
  - Any other next beat is counted as an error and the block goes to ERR.

Test Plan:
- Reset: hold rst low for 2 cycles -> all outputs 0, in_ready=0; one edge after release, in_ready=1 and locked=0.
- Clean stream: beats 1, 3, 9, 27 on consecutive cycles -> locked=1 from the cycle after the first beat, exponent=3, match_count=4, error_count=0.
- Mismatch: beats 1, 3, 10 -> error_flag pulses once in the cycle after 10; error_count=1; locked=0; in_ready=0 for 4 cycles, then 1.
- Resync: after the mismatch, beats 5, 7, 1, 3 -> 5 and 7 are not counted; locked=1 after 1; exponent=1; match_count=4.
- Overflow: beats 3^0 through 3^20, then 1870418611 -> with the macro, match and exponent=21; without it, error_count+1. Separately, beat 1 after 3^20 without the macro -> exponent=0, locked=1.
- Async reset mid-stream: pull rst low between edges after 3 matches -> outputs clear without waiting for a clock edge; after release, beat 1 relocks with match_count=1.
